// File: rtl/data_pack_pkg.sv
// Shared widths and types for the data_pack symbol-to-word packer.
// Optional build macro DATA_PACK_ERR_EN is consumed by the interface and top level.
package data_pack_pkg;

  localparam int SYM_W  = 7;
  localparam int WORD_W = 32;
  localparam int ACC_W  = WORD_W + SYM_W - 1;
  localparam int CNT_W  = $clog2(WORD_W) + 1;

  typedef logic [SYM_W-1:0]  sym_t;
  typedef logic [WORD_W-1:0] word_t;
  typedef logic [ACC_W-1:0]  acc_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  localparam cnt_t WORD_CNT = cnt_t'(WORD_W);
  localparam cnt_t SYM_CNT  = cnt_t'(SYM_W);

  // Keeps only the lowest n bits of a word; n at or above WORD_W keeps all of them.
  function automatic word_t low_mask(input cnt_t n);
    word_t m;
    if (n >= WORD_CNT) m = '1;
    else               m = (word_t'(1) << n) - word_t'(1);
    return m;
  endfunction

endpackage

// File: rtl/data_pack_if.sv
// Symbol-in / word-out stream bundle for data_pack.
// err_out exists only when DATA_PACK_ERR_EN is defined.
interface data_pack_if;
  import data_pack_pkg::*;

  logic  valid_in;
  sym_t  data_in;
  logic  sop_in;
  logic  eop_in;
  logic  ready_out;
  logic  valid_out;
  word_t data_out;
  logic  sop_out;
  logic  eop_out;
  cnt_t  bits_out;
  logic  ready_in;
`ifdef DATA_PACK_ERR_EN
  logic  err_out;
`endif

  modport slave (
    input  valid_in, data_in, sop_in, eop_in, ready_in,
`ifdef DATA_PACK_ERR_EN
    output err_out,
`endif
    output ready_out, valid_out, data_out, sop_out, eop_out, bits_out
  );

  modport master (
    output valid_in, data_in, sop_in, eop_in, ready_in,
`ifdef DATA_PACK_ERR_EN
    input  err_out,
`endif
    input  ready_out, valid_out, data_out, sop_out, eop_out, bits_out
  );

endinterface

// File: rtl/data_pack_out_reg.sv
// Output holding register: a one-entry valid/ready stage that keeps the
// packed word and its sop/eop/bits tags stable while downstream stalls.
module data_pack_out_reg
  import data_pack_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  load_valid_i,
  output logic  load_ready_o,
  input  word_t load_data_i,
  input  logic  load_sop_i,
  input  logic  load_eop_i,
  input  cnt_t  load_bits_i,
  input  logic  ready_i,
  output logic  valid_o,
  output word_t data_o,
  output logic  sop_o,
  output logic  eop_o,
  output cnt_t  bits_o
);

  logic  valid_q, valid_d;
  word_t data_q, data_d;
  logic  sop_q, sop_d;
  logic  eop_q, eop_d;
  cnt_t  bits_q, bits_d;

  assign load_ready_o = !valid_q || ready_i;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    sop_d   = sop_q;
    eop_d   = eop_q;
    bits_d  = bits_q;
    if (load_valid_i && load_ready_o) begin
      valid_d = 1'b1;
      data_d  = load_data_i;
      sop_d   = load_sop_i;
      eop_d   = load_eop_i;
      bits_d  = load_bits_i;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      bits_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      bits_q  <= bits_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign sop_o   = sop_q;
  assign eop_o   = eop_q;
  assign bits_o  = bits_q;

endmodule

// File: rtl/data_pack.sv
// Repacks a 7-bit symbol stream LSB-first into 32-bit words with sop/eop and
// a valid-bit count on the last word. Define DATA_PACK_ERR_EN for err_out.
module data_pack
  import data_pack_pkg::*;
(
  input logic         clk,
  input logic         rst,
  data_pack_if.slave  bus
);

  acc_t  acc_q, acc_d;
  cnt_t  count_q, count_d;
  logic  flush_q, flush_d;
  logic  sop_pend_q, sop_pend_d;
  logic  open_q, open_d;

  logic  accept;
  logic  slot_free;
  logic  emit;
  logic  final_word;
  word_t emit_data;
  cnt_t  emit_bits;

  assign bus.ready_out = !flush_q && (count_q < WORD_CNT);
  assign accept        = bus.valid_in && bus.ready_out;
  assign emit          = slot_free && ((count_q >= WORD_CNT) || flush_q);
  assign final_word    = flush_q && (count_q <= WORD_CNT);
  assign emit_data     = acc_q[WORD_W-1:0] & low_mask(count_q);
  assign emit_bits     = final_word ? count_q : WORD_CNT;

  // The emit drains first, so an accepted symbol lands just above what remains.
  always_comb begin
    acc_d      = acc_q;
    count_d    = count_q;
    flush_d    = flush_q;
    sop_pend_d = sop_pend_q;
    open_d     = open_q;
    if (emit) begin
      if (final_word) begin
        acc_d   = '0;
        count_d = '0;
        flush_d = 1'b0;
      end else begin
        acc_d   = acc_q >> WORD_W;
        count_d = count_q - WORD_CNT;
      end
      sop_pend_d = 1'b0;
    end
    if (accept) begin
      acc_d   = acc_d | (acc_t'(bus.data_in) << count_d);
      count_d = count_d + SYM_CNT;
      if (bus.sop_in && !open_q) sop_pend_d = 1'b1;
      if (bus.eop_in) begin
        flush_d = 1'b1;
        open_d  = 1'b0;
      end else if (bus.sop_in) begin
        open_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q      <= '0;
      count_q    <= '0;
      flush_q    <= 1'b0;
      sop_pend_q <= 1'b0;
      open_q     <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      count_q    <= count_d;
      flush_q    <= flush_d;
      sop_pend_q <= sop_pend_d;
      open_q     <= open_d;
    end
  end

  data_pack_out_reg u_out_reg (
    .clk          (clk),
    .rst          (rst),
    .load_valid_i (emit),
    .load_ready_o (slot_free),
    .load_data_i  (emit_data),
    .load_sop_i   (sop_pend_q),
    .load_eop_i   (final_word),
    .load_bits_i  (emit_bits),
    .ready_i      (bus.ready_in),
    .valid_o      (bus.valid_out),
    .data_o       (bus.data_out),
    .sop_o        (bus.sop_out),
    .eop_o        (bus.eop_out),
    .bits_o       (bus.bits_out)
  );

`ifdef DATA_PACK_ERR_EN
  logic err_q, err_d;

  // Sticky protocol error: a nested sop, or a symbol with no packet around it.
  always_comb begin
    err_d = err_q;
    if (accept && (bus.sop_in ? open_q : !open_q)) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= err_d;
  end

  assign bus.err_out = err_q;
`endif

endmodule
